ram_scan_ctrl: RTL and testbench

- Hardware engine that drives an emulated DUT's RAM scan chain. It replaces bench-driven pause/scan sequencing.
- Dump: pauses the DUT, shifts the chain out and streams each word to a consumer.
- Restore: pauses the DUT, shifts words from a producer into the chain, then resumes the DUT.
- Sits between the checkpoint DMA/host streams and the EMU_DUT ports emu_ram_se/sd/di/do. Its pause output feeds the DUT clock gates.

---
 rtl/ram_scan_pkg.sv | 24 ++
 rtl/ram_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_ram_scan_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_scan_pkg.sv
// rtl/ram_scan_pkg.sv - shared states, scan direction codes and counter width helper
// for the RAM scan-chain controller.
package ram_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_LEAD,
    S_SHIFT_OUT,
    S_SHIFT_IN,
    S_TAIL,
    S_DRAIN,
    S_RESUME
  } state_t;

  localparam logic DIR_DUMP    = 1'b0;
  localparam logic DIR_RESTORE = 1'b1;

  // Bits needed to hold the values 0..n inclusive, so a counter can reach n without wrapping.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ram_scan_ctrl.sv
// rtl/ram_scan_ctrl.sv - pause/scan sequencer that dumps an emulated DUT's RAM chain to a
// stream and restores it from a stream.
module ram_scan_ctrl
  import ram_scan_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int CHAIN_WORDS = 32,
  parameter int LEAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic                  cmd_restore,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  dut_pause,
  output logic                  ram_se,
  output logic                  ram_sd,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  localparam int WC_W = cnt_width(CHAIN_WORDS);
  localparam int LC_W = cnt_width(LEAD_CYCLES);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(CHAIN_WORDS - 1);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LEAD_CYCLES - 1);

  state_t            r_state;
  logic              r_dir;
  logic [WC_W-1:0]   r_word_cnt;
  logic [LC_W-1:0]   r_lead_cnt;
  logic              r_cmd_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_out_valid;
  logic              r_in_ready;
  logic              r_pause;
  logic              r_se;
  logic              r_sd;

  logic              w_out_hs;
  logic              w_in_hs;

  // Shift states advance the chain only on accepted words; LEAD and TAIL drive se from r_se.
  assign w_out_hs  = r_out_valid & out_ready;
  assign w_in_hs   = r_in_ready & in_valid;

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign dut_pause = r_pause;
  assign ram_se    = r_se | w_out_hs | w_in_hs;
  assign ram_sd    = r_sd;
  assign out_data  = ram_do;
  assign ram_di    = in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dir       <= DIR_DUMP;
      r_word_cnt  <= '0;
      r_lead_cnt  <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_pause     <= 1'b0;
      r_se        <= 1'b0;
      r_sd        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_dir       <= cmd_restore;
            r_word_cnt  <= '0;
            r_lead_cnt  <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_pause     <= 1'b1;
            r_state     <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (r_dir == DIR_RESTORE) begin
            r_sd       <= 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= S_SHIFT_IN;
          end else begin
            r_sd    <= 1'b0;
            r_se    <= 1'b1;
            r_state <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (r_lead_cnt == LC_LAST) begin
            r_se        <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_SHIFT_OUT;
          end else begin
            r_lead_cnt <= r_lead_cnt + LC_W'(1);
          end
        end
        S_SHIFT_OUT: begin
          if (w_out_hs) begin
            r_word_cnt <= r_word_cnt + WC_W'(1);
            if (r_word_cnt == WC_LAST) begin
              r_out_valid <= 1'b0;
              r_state     <= S_DRAIN;
            end
          end
        end
        S_SHIFT_IN: begin
          if (w_in_hs) begin
            r_word_cnt <= r_word_cnt + WC_W'(1);
            if (r_word_cnt == WC_LAST) begin
              r_in_ready <= 1'b0;
              r_se       <= 1'b1;
              r_state    <= S_TAIL;
            end
          end
        end
        S_TAIL: begin
          r_se    <= 1'b0;
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_pause <= 1'b0;
          r_state <= S_RESUME;
        end
        S_RESUME: begin
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// tb/tb_ram_scan_ctrl.sv - directed scoreboard bench for ram_scan_ctrl with a behavioural
// scan-chain model standing in for the emulated DUT memory.
module tb_ram_scan_ctrl;

  localparam int DW = 64;
  localparam int CW = 4;
  localparam int LC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_restore, cmd_ready, busy, done;
  logic          out_valid, out_ready, in_valid, in_ready;
  logic [DW-1:0] out_data, in_data, ram_di, ram_do;
  logic          dut_pause, ram_se, ram_sd;

  always #5 clk = ~clk;

  ram_scan_ctrl #(.DATA_WIDTH(DW), .CHAIN_WORDS(CW), .LEAD_CYCLES(LC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_restore(cmd_restore), .cmd_ready(cmd_ready),
    .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dut_pause(dut_pause), .ram_se(ram_se), .ram_sd(ram_sd),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  // Chain model: LC lead shifts before word 0 appears; restore passes through a one-word stage.
  logic [DW-1:0] mem     [CW];
  logic [DW-1:0] pre_mem [CW];
  logic [DW-1:0] stage;
  bit            stage_v;
  bit            load_req;
  int            lead, rptr, wptr;

  always @(posedge clk) begin
    if (!dut_pause) begin
      lead = 0; rptr = 0; wptr = 0; stage_v = 0;
      if (load_req) for (int i = 0; i < CW; i++) mem[i] = pre_mem[i];
    end else if (ram_se) begin
      if (!ram_sd) begin
        if (lead < LC) lead++;
        else rptr++;
      end else begin
        if (stage_v && wptr < CW) begin mem[wptr] = stage; wptr++; end
        stage   = ram_di;
        stage_v = 1;
      end
    end
  end

  assign ram_do = (lead >= LC && rptr < CW) ? mem[rptr] : '0;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rq[$];
  logic [DW-1:0] cap[$];
  logic [DW-1:0] orig [CW];
  int            first_c, done_c, pause_cnt, done_cnt, se_low, se_bad, overlap, n_out;
  bit            tail_se;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_chain();
    @(negedge clk);
    load_req = 1;
    @(negedge clk);
    load_req = 0;
  endtask

  task automatic push_expected();
    for (int i = 0; i < CW; i++) exp_q.push_back(pre_mem[i]);
  endtask

  // stall_a/stall_n: dump -> out_ready low on SHIFT_OUT cycles stall_a..stall_a+stall_n-1;
  // restore -> in_valid low for stall_n ready cycles after stall_a handshakes.
  task automatic run_op(input bit restore, input int stall_a, input int stall_n,
                        input int pulse_c, input int rst_idx);
    int c, idx, hs, drops, last_hs_c;
    bit aborted;
    logic [DW-1:0] e;
    first_c = -1; done_c = -1; pause_cnt = 0; done_cnt = 0;
    se_low = 0; se_bad = 0; overlap = 0; n_out = 0; tail_se = 0;
    c = 0; idx = 0; hs = 0; drops = 0; last_hs_c = -10; aborted = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_restore = restore; out_ready = 1; in_valid = 0;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    while (!aborted && !(done_c >= 0 && c >= done_c + 3) && c < 200) begin
      @(negedge clk);
      c++;
      cmd_valid = (c == pulse_c);
      if (cmd_valid) chk("cmd_ready_busy", cmd_ready, 0);
      pause_cnt += int'(dut_pause);
      if (done) begin done_cnt++; if (done_c < 0) done_c = c; end
      if (out_valid && in_ready) overlap++;
      out_ready = 1;
      if (out_valid && stall_n > 0 && idx + 1 >= stall_a && idx + 1 < stall_a + stall_n)
        out_ready = 0;
      in_valid = restore && (rq.size() > 0);
      if (in_ready && hs == stall_a && drops < stall_n) begin in_valid = 0; drops++; end
      in_data = (rq.size() > 0) ? rq[0] : '0;
      if (out_valid && idx + 1 == rst_idx) begin
        rst = 1;
        #1;
        chk("rst_pause", dut_pause, 0);
        chk("rst_se", ram_se, 0);
        chk("rst_out_valid", out_valid, 0);
        aborted = 1;
      end else begin
        #1;
        if (c == last_hs_c + 1) tail_se = ram_se && ram_sd;
        if (out_valid) begin
          idx++; n_out++;
          if (first_c < 0) first_c = c;
          if (!ram_se) se_low++;
          if (ram_se !== out_ready) se_bad++;
          if (out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk("dump_word", out_data, e);
            cap.push_back(out_data);
          end
        end
        if (in_ready && in_valid) begin
          void'(rq.pop_front());
          hs++;
          last_hs_c = c;
        end
      end
    end
    cmd_valid = 0;
  endtask

  initial begin
    rst = 1; cmd_valid = 0; cmd_restore = 0; out_ready = 0; in_valid = 0;
    in_data = '0; load_req = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outputs", {out_valid, in_ready, dut_pause, ram_se, ram_sd}, 0);
    rst = 0;

    for (int i = 0; i < CW; i++) pre_mem[i] = 64'hA0A0_0000_0000_0000 + 64'(i);
    load_chain();
    push_expected();
    run_op(0, 0, 0, -1, -1);
    chk("dump_first_valid", 64'(first_c), 64'(LC + 2));
    chk("dump_done", 64'(done_c), 64'(CW + LC + 4));
    chk("dump_pause_len", 64'(pause_cnt), 64'(CW + LC + 2));
    chk("dump_all_words", 64'(exp_q.size()), 0);
    chk("dump_no_in_ready", 64'(overlap), 0);

    push_expected();
    run_op(0, 2, 2, -1, -1);
    chk("stall_done", 64'(done_c), 64'(CW + LC + 6));
    chk("stall_se_low", 64'(se_low), 2);
    chk("stall_se_follow", 64'(se_bad), 0);
    chk("stall_all_words", 64'(exp_q.size()), 0);

    rq.delete();
    for (int i = 0; i < CW; i++) rq.push_back(64'hB0B0_0000_0000_0000 + 64'(i));
    run_op(1, 2, 3, -1, -1);
    chk("restore_done", 64'(done_c), 64'(CW + 8));
    chk("restore_tail_se", 64'(tail_se), 1);
    chk("restore_no_out_valid", 64'(n_out), 0);
    for (int i = 0; i < CW; i++) chk("restore_chain", mem[i], 64'hB0B0_0000_0000_0000 + 64'(i));

    load_chain();
    push_expected();
    run_op(0, 0, 0, 5, -1);
    chk("busy_done_cnt", 64'(done_cnt), 1);
    chk("busy_done", 64'(done_c), 64'(CW + LC + 4));
    chk("busy_pause_len", 64'(pause_cnt), 64'(CW + LC + 2));
    chk("busy_idle_after", busy, 0);

    push_expected();
    run_op(0, 0, 0, -1, 2);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    exp_q.delete();
    push_expected();
    run_op(0, 0, 0, -1, -1);
    chk("post_rst_done", 64'(done_c), 64'(CW + LC + 4));
    chk("post_rst_words", 64'(exp_q.size()), 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < CW; i++) begin
        pre_mem[i] = {$urandom, $urandom};
        orig[i]    = pre_mem[i];
      end
      load_chain();
      push_expected();
      cap.delete();
      run_op(0, 0, 0, -1, -1);
      for (int i = 0; i < CW; i++) pre_mem[i] = ~orig[i];
      load_chain();
      rq = cap;
      run_op(1, 0, 0, -1, -1);
      for (int i = 0; i < CW; i++) chk("roundtrip", mem[i], orig[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
